area_bcd_formatter: RTL and testbench

- Downstream stage of the triangle-area unit in the calculator datapath.
- Consumes the 10-bit integer area and the 2-bit half-remainder.
- Converts the integer part to 4 BCD digits with an iterative shift-add-3 (double-dabble) sequencer, and produces a fractional tenths digit (0 or 5).
- Feeds the display/result mux with a one-cycle done strobe.

---
 rtl/area_bcd_formatter.sv | 165 ++++++++++++++++
 tb/tb_area_bcd_formatter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/area_bcd_formatter.sv
// Converts the integer triangle area to BCD with a double-dabble sequencer and adds a tenths digit.
// Optional leading-zero blank mask output is enabled by defining AREA_BCD_BLANK_EN.
module area_bcd_formatter #(
    parameter int IN_W   = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       q_area,
    input  logic [1:0]            r_area,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_int,
    output logic [3:0]            frac_digit
`ifdef AREA_BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [IN_W-1:0]    shift_r, shift_s;
    logic [BCD_W-1:0]   scratch_r, scratch_s, scratch_adj_s, bcd_int_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               frac_r, frac_s;
    logic               busy_s, done_s;
    logic [3:0]         frac_digit_s;
    logic               unused_r_area_s;

    // Only bit0 of the remainder carries the half; bit1 is intentionally dropped.
    assign unused_r_area_s = r_area[1];

    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef AREA_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_s;

    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = {DIGITS{1'b0}};
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (v[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        m[0] = 1'b0;
        return m;
    endfunction
`endif

    // Next-state and datapath next values.
    always_comb begin
        state_s       = state_r;
        shift_s       = shift_r;
        scratch_s     = scratch_r;
        cnt_s         = cnt_r;
        frac_s        = frac_r;
        busy_s        = busy;
        done_s        = 1'b0;
        bcd_int_s     = bcd_int;
        frac_digit_s  = frac_digit;
        scratch_adj_s = add3_nibbles(scratch_r);
`ifdef AREA_BCD_BLANK_EN
        blank_s       = blank;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    shift_s   = q_area;
                    frac_s    = r_area[0];
                    scratch_s = {BCD_W{1'b0}};
                    cnt_s     = {CNT_W{1'b0}};
                    state_s   = SHIFT;
                    busy_s    = 1'b1;
                end else begin
                    state_s   = IDLE;
                    busy_s    = 1'b0;
                end
            end
            SHIFT: begin
                scratch_s = {scratch_adj_s[BCD_W-2:0], shift_r[IN_W-1]};
                shift_s   = {shift_r[IN_W-2:0], 1'b0};
                cnt_s     = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_ITER) begin
                    state_s      = DONE;
                    busy_s       = 1'b0;
                    done_s       = 1'b1;
                    bcd_int_s    = scratch_s;
                    frac_digit_s = frac_r ? 4'd5 : 4'd0;
`ifdef AREA_BCD_BLANK_EN
                    blank_s      = blank_mask(scratch_s);
`endif
                end else begin
                    busy_s       = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= {IN_W{1'b0}};
            scratch_r  <= {BCD_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            frac_r     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd_int    <= {BCD_W{1'b0}};
            frac_digit <= 4'd0;
`ifdef AREA_BCD_BLANK_EN
            blank      <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            shift_r    <= shift_s;
            scratch_r  <= scratch_s;
            cnt_r      <= cnt_s;
            frac_r     <= frac_s;
            busy       <= busy_s;
            done       <= done_s;
            bcd_int    <= bcd_int_s;
            frac_digit <= frac_digit_s;
`ifdef AREA_BCD_BLANK_EN
            blank      <= blank_s;
`endif
        end
    end

endmodule

// File: tb/tb_area_bcd_formatter.sv
// Directed bench for area_bcd_formatter: latency, results, ignored starts, back-to-back, reset abort.
module tb_area_bcd_formatter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  q_area;
    logic [1:0]  r_area;
    logic        busy;
    logic        done;
    logic [15:0] bcd_int;
    logic [3:0]  frac_digit;
`ifdef AREA_BCD_BLANK_EN
    logic [3:0]  blank;
`endif

    int checks = 0;
    int errors = 0;

    area_bcd_formatter #(.IN_W(10), .DIGITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .q_area     (q_area),
        .r_area     (r_area),
        .busy       (busy),
        .done       (done),
        .bcd_int    (bcd_int),
        .frac_digit (frac_digit)
`ifdef AREA_BCD_BLANK_EN
        ,
        .blank      (blank)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_blank(input string tag, input logic [3:0] exp);
`ifdef AREA_BCD_BLANK_EN
        check_eq(tag, {28'd0, blank}, {28'd0, exp});
`endif
    endtask

    // Drive a one-cycle start; returns at the negedge after the accepting edge.
    task automatic start_conv(input logic [9:0] q, input logic [1:0] r);
        start  = 1'b1;
        q_area = q;
        r_area = r;
        @(negedge clk);
        start  = 1'b0;
        check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Wait for done, counting edges since acceptance and busy-high cycles.
    task automatic wait_done(input bit pulses, input bit scramble, input logic [15:0] prev,
                             output int lat, output int bcnt, output bit changed);
        lat     = 0;
        bcnt    = busy ? 1 : 0;
        changed = 1'b0;
        if (bcd_int !== prev) changed = 1'b1;
        while (!done && lat < 20) begin
            start = pulses && (lat == 3 || lat == 7);
            if (scramble) begin
                q_area = 10'($urandom_range(0, 1023));
                r_area = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (!done && bcd_int !== prev) changed = 1'b1;
        end
        start = 1'b0;
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    int lat, bcnt, nd;
    bit changed;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        q_area = 10'd0;
        r_area = 2'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_bcd", {16'd0, bcd_int}, 32'h0000);
        check_eq("rst_frac", {28'd0, frac_digit}, 32'd0);
        check_blank("rst_blank", 4'b1110);
        rst = 1'b0;
        @(negedge clk);

        // Zero input
        start_conv(10'd0, 2'd0);
        wait_done(1'b0, 1'b0, 16'h0000, lat, bcnt, changed);
        check_eq("t1_latency", lat, 32'd10);
        check_eq("t1_bcd", {16'd0, bcd_int}, 32'h0000);
        check_eq("t1_frac", {28'd0, frac_digit}, 32'd0);
        check_eq("t1_busy_in_done", {31'd0, busy}, 32'd0);
        check_blank("t1_blank", 4'b1110);
        @(negedge clk);
        check_eq("t1_done_one_cycle", {31'd0, done}, 32'd0);

        // Maximum input with half
        start_conv(10'd1023, 2'd1);
        wait_done(1'b0, 1'b0, 16'h0000, lat, bcnt, changed);
        check_eq("t2_latency", lat, 32'd10);
        check_eq("t2_busy_cycles", bcnt, 32'd10);
        check_eq("t2_bcd", {16'd0, bcd_int}, 32'h1023);
        check_eq("t2_frac", {28'd0, frac_digit}, 32'd5);
        check_blank("t2_blank", 4'b0000);
        @(negedge clk);

        // Extra starts during the conversion are ignored
        start_conv(10'd347, 2'd0);
        wait_done(1'b1, 1'b0, 16'h1023, lat, bcnt, changed);
        check_eq("t3_latency", lat, 32'd10);
        check_eq("t3_bcd", {16'd0, bcd_int}, 32'h0347);
        check_eq("t3_frac", {28'd0, frac_digit}, 32'd0);
        check_blank("t3_blank", 4'b1000);
        count_dones(15, nd);
        check_eq("t3_single_done", nd, 32'd0);

        // Back-to-back: start held in the DONE cycle
        start_conv(10'd5, 2'd1);
        wait_done(1'b0, 1'b0, 16'h0347, lat, bcnt, changed);
        check_eq("t4a_bcd", {16'd0, bcd_int}, 32'h0005);
        check_eq("t4a_frac", {28'd0, frac_digit}, 32'd5);
        check_eq("t4a_done", {31'd0, done}, 32'd1);
        start_conv(10'd9, 2'd2);
        check_eq("t4_done_cleared", {31'd0, done}, 32'd0);
        wait_done(1'b0, 1'b0, 16'h0005, lat, bcnt, changed);
        check_eq("t4_latency", lat, 32'd10);
        check_eq("t4_bcd", {16'd0, bcd_int}, 32'h0009);
        check_eq("t4_frac", {28'd0, frac_digit}, 32'd0);
        check_blank("t4_blank", 4'b1110);
        @(negedge clk);

        // Reset mid-conversion
        start_conv(10'd500, 2'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t5_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_done", {31'd0, done}, 32'd0);
        check_eq("t5_bcd", {16'd0, bcd_int}, 32'h0000);
        check_eq("t5_frac", {28'd0, frac_digit}, 32'd0);
        check_blank("t5_blank", 4'b1110);
        count_dones(15, nd);
        check_eq("t5_no_done", nd, 32'd0);
        start_conv(10'd88, 2'd0);
        wait_done(1'b0, 1'b0, 16'h0000, lat, bcnt, changed);
        check_eq("t5_latency", lat, 32'd10);
        check_eq("t5_bcd_after", {16'd0, bcd_int}, 32'h0088);
        check_blank("t5_blank_after", 4'b1100);
        @(negedge clk);

        // Inputs scrambled during SHIFT; output held until done
        start_conv(10'd256, 2'd1);
        wait_done(1'b0, 1'b1, 16'h0088, lat, bcnt, changed);
        check_eq("t6_latency", lat, 32'd10);
        check_eq("t6_hold", {31'd0, changed}, 32'd0);
        check_eq("t6_bcd", {16'd0, bcd_int}, 32'h0256);
        check_eq("t6_frac", {28'd0, frac_digit}, 32'd5);
        check_blank("t6_blank", 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
